// File: rtl/minisys_timer.sv
// minisys_timer: memory-mapped dual-channel timer/counter on the Minisys1A MEM-stage IO bus.
// Latency: writes visible one cycle later, reads combinational, pulse edge decrements 3 clk after sampling.
// Backpressure: none; every access completes in the cycle it is presented.
module minisys_timer #(
    parameter logic [31:0] BASE  = 32'hFFFF_FC20,
    parameter int          WIDTH = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr,
    input  logic [3:0]  we,
    input  logic        re,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    input  logic        pulse0,
    input  logic        pulse1,
    output logic        cout0,
    output logic        cout1
);

    localparam int               NCH = 2;
    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    // Bus decode: a 16-byte aligned window, word accesses only.
    logic       hit;
    logic       wr_en;
    logic       rd_en;
    logic [1:0] off;

    assign hit   = (addr[31:4] == BASE[31:4]) && (addr[1:0] == 2'b00);
    assign off   = addr[3:2];
    assign wr_en = hit && (we != 4'b0000);
    assign rd_en = hit && re;

    // Only the low WIDTH bits of the write bus carry register data.
    logic unused_wdata_hi;
    assign unused_wdata_hi = ^wdata[31:WIDTH];

    // Per-channel architectural state.
    logic [WIDTH-1:0] mode_q  [NCH];
    logic [WIDTH-1:0] mode_d  [NCH];
    logic [WIDTH-1:0] init_q  [NCH];
    logic [WIDTH-1:0] init_d  [NCH];
    logic [WIDTH-1:0] count_q [NCH];
    logic [WIDTH-1:0] count_d [NCH];
    logic [1:0]       flag_q  [NCH];
    logic [1:0]       flag_d  [NCH];
    logic [NCH-1:0]   run_q;
    logic [NCH-1:0]   run_d;

    // External pulse path: two synchronizer flops, a history flop and the edge register.
    logic [NCH-1:0] pulse_v;
    logic [NCH-1:0] sync1_q;
    logic [NCH-1:0] sync2_q;
    logic [NCH-1:0] sync3_q;
    logic [NCH-1:0] edge_q;
    logic [NCH-1:0] edge_d;

    // Terminal-count strobe register and per-cycle event terms.
    logic [NCH-1:0] cout_q;
    logic [NCH-1:0] cout_d;
    logic [NCH-1:0] dec;
    logic [NCH-1:0] tc;
    logic [NCH-1:0] mode_wr;
    logic [NCH-1:0] init_wr;
    logic [NCH-1:0] stat_rd;

    assign pulse_v = {pulse1, pulse0};

    // Next-state for every channel: decrement/reload first, then bus writes override.
    always_comb begin
        edge_d  = sync2_q & ~sync3_q;
        dec     = '0;
        tc      = '0;
        mode_wr = '0;
        init_wr = '0;
        stat_rd = '0;
        run_d   = run_q;
        cout_d  = '0;
        for (int ch = 0; ch < NCH; ch++) begin
            mode_d[ch]  = mode_q[ch];
            init_d[ch]  = init_q[ch];
            count_d[ch] = count_q[ch];
            flag_d[ch]  = flag_q[ch];

            mode_wr[ch] = wr_en && (off == 2'(ch));
            init_wr[ch] = wr_en && (off == 2'(ch + 2));
            stat_rd[ch] = rd_en && (off == 2'(ch));

            // Timer source decrements every cycle, counter source only on a detected edge.
            dec[ch] = run_q[ch] && (mode_q[ch][0] ? edge_q[ch] : 1'b1);
            tc[ch]  = dec[ch] && (count_q[ch] == ONE);

            if (dec[ch]) begin
                if (tc[ch]) begin
                    if (mode_q[ch][1]) begin
                        // Skip the zero state so the repeat period is exactly init cycles.
                        count_d[ch] = init_q[ch];
                    end else begin
                        count_d[ch] = '0;
                        run_d[ch]   = 1'b0;
                    end
                end else begin
                    count_d[ch] = count_q[ch] - ONE;
                end
            end

            // A mode write stops the channel; the count it had reached is left in place.
            if (mode_wr[ch]) begin
                mode_d[ch] = wdata[WIDTH-1:0];
                run_d[ch]  = 1'b0;
            end

            // An init write restarts the channel unless the value is zero.
            if (init_wr[ch]) begin
                init_d[ch]  = wdata[WIDTH-1:0];
                count_d[ch] = wdata[WIDTH-1:0];
                run_d[ch]   = (wdata[WIDTH-1:0] != '0);
            end

            // Read-to-clear, but a flag set in the same cycle survives.
            if (stat_rd[ch]) begin
                flag_d[ch] = 2'b00;
            end
            if (tc[ch]) begin
                flag_d[ch][mode_q[ch][0]] = 1'b1;
            end

            // Predict next cycle's terminal count so cout is a plain flop aligned with tc.
            cout_d[ch] = run_d[ch] && (count_d[ch] == ONE)
                         && (mode_d[ch][0] ? edge_d[ch] : 1'b1);
        end
    end

    // Pulse synchronizer and registered rising-edge detector.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
            sync3_q <= '0;
            edge_q  <= '0;
        end else begin
            sync1_q <= pulse_v;
            sync2_q <= sync1_q;
            sync3_q <= sync2_q;
            edge_q  <= edge_d;
        end
    end

    // Channel registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int ch = 0; ch < NCH; ch++) begin
                mode_q[ch]  <= '0;
                init_q[ch]  <= '0;
                count_q[ch] <= '0;
                flag_q[ch]  <= '0;
            end
            run_q <= '0;
        end else begin
            for (int ch = 0; ch < NCH; ch++) begin
                mode_q[ch]  <= mode_d[ch];
                init_q[ch]  <= init_d[ch];
                count_q[ch] <= count_d[ch];
                flag_q[ch]  <= flag_d[ch];
            end
            run_q <= run_d;
        end
    end

    // Terminal-count strobe register; high exactly in the cycle the terminal decrement occurs.
    always_ff @(posedge clk) begin
        if (rst) begin
            cout_q <= '0;
        end else begin
            cout_q <= cout_d;
        end
    end

    assign cout0 = cout_q[0];
    assign cout1 = cout_q[1];

    // Read mux: status words at offsets 0x0/0x4, live counts at 0x8/0xC, zero otherwise.
    always_comb begin
        rdata = '0;
        if (rd_en) begin
            case (off)
                2'd0, 2'd1: begin
                    rdata[15]  = run_q[off[0]];
                    rdata[1:0] = flag_q[off[0]];
                end
                default: begin
                    rdata[WIDTH-1:0] = count_q[off[0]];
                end
            endcase
        end
    end

endmodule
